// File: rtl/i2c_target_regs.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2c_target_regs
//
// I2C target (slave) that exposes a small file of 8-bit registers. A write
// transaction carries a register pointer byte followed by data bytes, which
// are stored at the pointer with auto-increment and wrap-around.
//
// The bus is sampled entirely in the CLK domain through two-flop
// synchronisers. CLK must run at least 16x faster than SCL.
//
// Parameters:
//   ADDR      7-bit bus address this target answers to
//   NUM_REGS  number of 8-bit registers (1..16)
//
// Ports:
//   CLK     system clock, rising edge only
//   RST     synchronous active-high reset
//   SCL     bus clock from the controller (asynchronous)
//   SDA_IN  sampled bus data line (asynchronous)
//   SDA_OE  1 = pull SDA low, 0 = release (open-drain pad is outside)
//   REGS    register file, flattened, reg k at [8k+7:8k]
//   BUSY    high from an addressed START match until STOP / next START
//   OK      one-CLK pulse for every data byte written into REGS
//
// Build option:
//   I2C_TARGET_READ_EN  when defined, read transactions are supported;
//                       otherwise a matching read address is NACKed.
// ---------------------------------------------------------------------------
module i2c_target_regs #(
  parameter logic [6:0] ADDR     = 7'h42,
  parameter int         NUM_REGS = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SCL,
  input  logic                  SDA_IN,
  output logic                  SDA_OE,
  output logic [NUM_REGS*8-1:0] REGS,
  output logic                  BUSY,
  output logic                  OK
);

  localparam int            PW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [PW-1:0] LAST_PTR  = PW'(NUM_REGS - 1);
  localparam logic [8:0]    REG_LIMIT = 9'(NUM_REGS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
`ifdef I2C_TARGET_READ_EN
    S_RDATA,
    S_RDATA_ACK,
`endif
    S_IGNORE
  } state_t;

  state_t        r_state;
  logic [1:0]    r_sclSync;
  logic [1:0]    r_sdaSync;
  logic          r_sclPrev;
  logic          r_sdaPrev;
  logic [6:0]    r_shift;
  logic [2:0]    r_bitCnt;
  logic          r_ackOn;
  logic [PW-1:0] r_ptr;
  logic [7:0]    r_regs [NUM_REGS];
`ifdef I2C_TARGET_READ_EN
  logic          r_isRead;
  logic [7:0]    r_txByte;
`endif

  logic          w_scl;
  logic          w_sda;
  logic          w_sclRise;
  logic          w_sclFall;
  logic          w_start;
  logic          w_stop;
  logic [7:0]    w_byte;
  logic          w_lastBit;
  logic [PW-1:0] w_ptrNext;

  // Synchronisers reset to 1 so a reset looks like an idle bus.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sclSync <= 2'b11;
      r_sdaSync <= 2'b11;
      r_sclPrev <= 1'b1;
      r_sdaPrev <= 1'b1;
    end else begin
      r_sclSync <= {r_sclSync[0], SCL};
      r_sdaSync <= {r_sdaSync[0], SDA_IN};
      r_sclPrev <= w_scl;
      r_sdaPrev <= w_sda;
    end
  end

  assign w_scl     = r_sclSync[1];
  assign w_sda     = r_sdaSync[1];
  assign w_sclRise = w_scl & ~r_sclPrev;
  assign w_sclFall = ~w_scl & r_sclPrev;
  // SCL must be stably high across both samples for START/STOP.
  assign w_start   = w_scl & r_sclPrev & r_sdaPrev & ~w_sda;
  assign w_stop    = w_scl & r_sclPrev & ~r_sdaPrev & w_sda;
  // Byte as it will look once the bit on this rising edge is shifted in.
  assign w_byte    = {r_shift, w_sda};
  assign w_lastBit = (r_bitCnt == 3'd7);
  assign w_ptrNext = (r_ptr == LAST_PTR) ? '0 : r_ptr + PW'(1);

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regsOut
    assign REGS[8*k +: 8] = r_regs[k];
  end

  // Protocol FSM. ACK states use r_ackOn to tell the first SCL fall
  // (start driving the ACK) from the second (release and move on).
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      SDA_OE   <= 1'b0;
      BUSY     <= 1'b0;
      OK       <= 1'b0;
      r_ptr    <= '0;
      r_shift  <= '0;
      r_bitCnt <= '0;
      r_ackOn  <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        r_regs[k] <= 8'h00;
      end
`ifdef I2C_TARGET_READ_EN
      r_isRead <= 1'b0;
      r_txByte <= '0;
`endif
    end else begin
      OK <= 1'b0;
      if (w_stop) begin
        r_state <= S_IDLE;
        SDA_OE  <= 1'b0;
        BUSY    <= 1'b0;
      end else if (w_start) begin
        r_state  <= S_ADDR;
        r_bitCnt <= '0;
        SDA_OE   <= 1'b0;
        BUSY     <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_sclRise) begin
              r_shift  <= w_byte[6:0];
              r_bitCnt <= r_bitCnt + 3'd1;
              if (w_lastBit) begin
                r_ackOn <= 1'b0;
                if (w_byte[7:1] == ADDR) begin
`ifdef I2C_TARGET_READ_EN
                  r_isRead <= w_byte[0];
                  r_state  <= S_ADDR_ACK;
                  BUSY     <= 1'b1;
`else
                  if (w_byte[0]) begin
                    r_state <= S_IGNORE;
                  end else begin
                    r_state <= S_ADDR_ACK;
                    BUSY    <= 1'b1;
                  end
`endif
                end else begin
                  r_state <= S_IGNORE;
                end
              end
            end
          end

          S_ADDR_ACK: begin
            if (w_sclFall) begin
              if (!r_ackOn) begin
                SDA_OE  <= 1'b1;
                r_ackOn <= 1'b1;
              end else begin
                r_ackOn  <= 1'b0;
                r_bitCnt <= '0;
`ifdef I2C_TARGET_READ_EN
                if (r_isRead) begin
                  // First data bit goes out on the same fall that ends the ACK.
                  r_txByte <= r_regs[r_ptr];
                  SDA_OE   <= ~r_regs[r_ptr][7];
                  r_state  <= S_RDATA;
                end else begin
                  SDA_OE  <= 1'b0;
                  r_state <= S_PTR;
                end
`else
                SDA_OE  <= 1'b0;
                r_state <= S_PTR;
`endif
              end
            end
          end

          S_PTR: begin
            if (w_sclRise) begin
              r_shift  <= w_byte[6:0];
              r_bitCnt <= r_bitCnt + 3'd1;
              if (w_lastBit) begin
                r_ackOn <= 1'b0;
                if ({1'b0, w_byte} < REG_LIMIT) begin
                  r_ptr   <= w_byte[PW-1:0];
                  r_state <= S_PTR_ACK;
                end else begin
                  r_state <= S_IGNORE;
                end
              end
            end
          end

          S_PTR_ACK, S_WDATA_ACK: begin
            if (w_sclFall) begin
              if (!r_ackOn) begin
                SDA_OE  <= 1'b1;
                r_ackOn <= 1'b1;
              end else begin
                SDA_OE   <= 1'b0;
                r_ackOn  <= 1'b0;
                r_bitCnt <= '0;
                r_state  <= S_WDATA;
              end
            end
          end

          S_WDATA: begin
            if (w_sclRise) begin
              r_shift  <= w_byte[6:0];
              r_bitCnt <= r_bitCnt + 3'd1;
              if (w_lastBit) begin
                r_regs[r_ptr] <= w_byte;
                OK            <= 1'b1;
                r_ptr         <= w_ptrNext;
                r_ackOn       <= 1'b0;
                r_state       <= S_WDATA_ACK;
              end
            end
          end

`ifdef I2C_TARGET_READ_EN
          S_RDATA: begin
            if (w_sclFall) begin
              if (w_lastBit) begin
                SDA_OE  <= 1'b0;
                r_ptr   <= w_ptrNext;
                r_ackOn <= 1'b0;
                r_state <= S_RDATA_ACK;
              end else begin
                r_txByte <= {r_txByte[6:0], 1'b0};
                SDA_OE   <= ~r_txByte[6];
                r_bitCnt <= r_bitCnt + 3'd1;
              end
            end
          end

          // r_ackOn here records that the controller ACKed the byte.
          S_RDATA_ACK: begin
            if (w_sclRise) begin
              if (w_sda) begin
                r_state <= S_IGNORE;
              end else begin
                r_ackOn <= 1'b1;
              end
            end else if (w_sclFall && r_ackOn) begin
              r_ackOn  <= 1'b0;
              r_txByte <= r_regs[r_ptr];
              SDA_OE   <= ~r_regs[r_ptr][7];
              r_bitCnt <= '0;
              r_state  <= S_RDATA;
            end
          end
`endif

          default: begin
            SDA_OE <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_i2c_target_regs
//
// Bus-level testbench: an I2C controller built from tasks drives SCL/SDA,
// and an open-drain wired-AND joins it with the target's SDA_OE. A plain
// array model of the register file and pointer supplies expected values.
// ---------------------------------------------------------------------------
module tb_i2c_target_regs;

  localparam int         NUM_REGS = 4;
  localparam logic [6:0] ADDR     = 7'h42;
  localparam int         Q        = 100;

  logic                  CLK;
  logic                  RST;
  logic                  SCL;
  logic                  ctlSda;
  logic                  SDA_IN;
  logic                  SDA_OE;
  logic [NUM_REGS*8-1:0] REGS;
  logic                  BUSY;
  logic                  OK;

  int checkCount = 0;
  int passCount  = 0;
  int okCount    = 0;
  int oeCount    = 0;

  logic [7:0] modelRegs [NUM_REGS];
  int         modelPtr;
  logic [7:0] txQ [$];

  i2c_target_regs #(.ADDR(ADDR), .NUM_REGS(NUM_REGS)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .SCL    (SCL),
    .SDA_IN (SDA_IN),
    .SDA_OE (SDA_OE),
    .REGS   (REGS),
    .BUSY   (BUSY),
    .OK     (OK)
  );

  // Open-drain bus: either side can pull SDA low.
  assign SDA_IN = ctlSda & ~SDA_OE;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (OK)     okCount <= okCount + 1;
    if (SDA_OE) oeCount <= oeCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [NUM_REGS*8-1:0] modelFlat();
    logic [NUM_REGS*8-1:0] f;
    for (int k = 0; k < NUM_REGS; k++) f[8*k +: 8] = modelRegs[k];
    return f;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NUM_REGS; k++) modelRegs[k] = 8'h00;
    modelPtr = 0;
  endtask

  // Expected ACK per byte of txQ, register updates and OK pulses.
  task automatic modelWrite(output logic [15:0] expAcks, output int expOk);
    expAcks = '0;
    expOk   = 0;
    if (txQ[0] != {ADDR, 1'b0}) return;
    expAcks[0] = 1'b1;
    if (txQ.size() < 2) return;
    if (int'(txQ[1]) >= NUM_REGS) return;
    expAcks[1] = 1'b1;
    modelPtr   = int'(txQ[1]);
    for (int i = 2; i < txQ.size(); i++) begin
      expAcks[i]          = 1'b1;
      modelRegs[modelPtr] = txQ[i];
      modelPtr            = (modelPtr + 1) % NUM_REGS;
      expOk++;
    end
  endtask

  task automatic busStart();
    ctlSda = 1'b1; #Q;
    SCL    = 1'b1; #Q;
    ctlSda = 1'b0; #Q;
    SCL    = 1'b0; #Q;
  endtask

  task automatic busStop();
    ctlSda = 1'b0; #Q;
    SCL    = 1'b1; #Q;
    ctlSda = 1'b1; #(2*Q);
  endtask

  task automatic clockBit(input logic b, output logic s);
    ctlSda = b; #Q;
    SCL    = 1'b1; #Q;
    s      = SDA_IN; #Q;
    SCL    = 1'b0; #Q;
  endtask

  task automatic sendByte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clockBit(d[i], s);
    clockBit(1'b1, s);
    ack = ~s;
  endtask

  task automatic readByte(input logic giveAck, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) clockBit(1'b1, d[i]);
    clockBit(~giveAck, s);
  endtask

  // Full write transaction from txQ: START, bytes until a NACK, STOP.
  task automatic applyStimulus(input string tag);
    logic [15:0] gotAcks;
    logic [15:0] expAcks;
    int          expOk;
    int          okBefore;
    int          oeBefore;
    logic        a;
    gotAcks  = '0;
    okBefore = okCount;
    oeBefore = oeCount;
    modelWrite(expAcks, expOk);
    busStart();
    for (int i = 0; i < txQ.size(); i++) begin
      sendByte(txQ[i], a);
      gotAcks[i] = a;
      if (i == 0) checkOutput({tag, " busy"}, 64'(BUSY), 64'(expAcks[0]));
      if (!a) break;
    end
    busStop();
    repeat (2) @(negedge CLK);
    checkOutput({tag, " acks"}, 64'(gotAcks), 64'(expAcks));
    checkOutput({tag, " okPulses"}, 64'(okCount - okBefore), 64'(expOk));
    checkOutput({tag, " regs"}, 64'(REGS), 64'(modelFlat()));
    checkOutput({tag, " busyAfterStop"}, 64'(BUSY), 64'(0));
    if (!expAcks[0]) checkOutput({tag, " oeNever"}, 64'(oeCount - oeBefore), 64'(0));
  endtask

  initial begin
    logic       a;
    logic       s;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [15:0] expAcks;
    int         expOk;
    int         okBefore;
    int         oeBefore;

    RST    = 1'b1;
    SCL    = 1'b1;
    ctlSda = 1'b1;
    modelReset();
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset SDA_OE", 64'(SDA_OE), 64'(0));
    checkOutput("reset BUSY", 64'(BUSY), 64'(0));
    checkOutput("reset OK", 64'(OK), 64'(0));
    checkOutput("reset REGS", 64'(REGS), 64'(0));
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    $display("[TB] basic write");
    txQ = '{8'h84, 8'h01, 8'hA5};
    applyStimulus("write");
    checkOutput("write reg1", 64'(REGS[15:8]), 64'(8'hA5));

    $display("[TB] burst wrap");
    txQ = '{8'h84, 8'h03, 8'h11, 8'h22};
    applyStimulus("wrap");
    checkOutput("wrap reg3", 64'(REGS[31:24]), 64'(8'h11));
    checkOutput("wrap reg0", 64'(REGS[7:0]), 64'(8'h22));

    $display("[TB] rejects");
    txQ = '{8'h90, 8'h00, 8'h77};
    applyStimulus("badAddr");
    txQ = '{8'h84, 8'h07, 8'h55};
    applyStimulus("badPtr");

    $display("[TB] read via repeated START");
    txQ = '{8'h84, 8'h01};
    modelWrite(expAcks, expOk);
    busStart();
    sendByte(8'h84, a);
    sendByte(8'h01, a);
    checkOutput("read ptrAck", 64'(a), 64'(1));
    busStart();
    sendByte(8'h85, a);
`ifdef I2C_TARGET_READ_EN
    checkOutput("read addrAck", 64'(a), 64'(1));
    readByte(1'b1, d0);
    readByte(1'b0, d1);
    checkOutput("read byte0", 64'(d0), 64'(modelRegs[1]));
    checkOutput("read byte1", 64'(d1), 64'(modelRegs[2]));
    modelPtr = (modelPtr + 2) % NUM_REGS;
`else
    checkOutput("read addrNack", 64'(a), 64'(0));
`endif
    busStop();
    repeat (2) @(negedge CLK);
    checkOutput("read busyAfterStop", 64'(BUSY), 64'(0));
    checkOutput("read regs", 64'(REGS), 64'(modelFlat()));

    $display("[TB] randomized writes");
    for (int t = 0; t < 10; t++) begin
      logic [6:0] ad;
      int         len;
      ad  = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : ADDR;
      txQ.delete();
      txQ.push_back({ad, 1'b0});
      if ($urandom_range(0, 3) == 0) txQ.push_back(8'($urandom_range(4, 255)));
      else txQ.push_back(8'($urandom_range(0, NUM_REGS - 1)));
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) txQ.push_back(8'($urandom));
      applyStimulus($sformatf("rand%0d", t));
    end

    $display("[TB] abort with STOP mid-byte");
    txQ = '{8'h84, 8'h02};
    modelWrite(expAcks, expOk);
    okBefore = okCount;
    busStart();
    sendByte(8'h84, a);
    sendByte(8'h02, a);
    for (int i = 0; i < 4; i++) clockBit(1'($urandom), s);
    busStop();
    repeat (2) @(negedge CLK);
    checkOutput("abort regs", 64'(REGS), 64'(modelFlat()));
    checkOutput("abort okPulses", 64'(okCount - okBefore), 64'(0));
    checkOutput("abort busy", 64'(BUSY), 64'(0));

    $display("[TB] reset during address ACK");
    busStart();
    for (int i = 7; i >= 0; i--) clockBit(txQ[0][i], s);
    checkOutput("ackDriven", 64'(SDA_OE), 64'(1));
    @(negedge CLK) RST = 1'b1;
    @(negedge CLK) RST = 1'b0;
    modelReset();
    checkOutput("rstAck SDA_OE", 64'(SDA_OE), 64'(0));
    checkOutput("rstAck BUSY", 64'(BUSY), 64'(0));
    clockBit(1'b1, s);
    busStop();

    $display("[TB] reset mid-byte of a write");
    txQ = '{8'h84, 8'h00, 8'h3C};
    busStart();
    sendByte(8'h84, a);
    sendByte(8'h00, a);
    for (int i = 7; i >= 5; i--) clockBit(txQ[2][i], s);
    @(negedge CLK) RST = 1'b1;
    @(negedge CLK) RST = 1'b0;
    checkOutput("rstMid SDA_OE", 64'(SDA_OE), 64'(0));
    checkOutput("rstMid BUSY", 64'(BUSY), 64'(0));
    checkOutput("rstMid OK", 64'(OK), 64'(0));
    checkOutput("rstMid REGS", 64'(REGS), 64'(0));
    okBefore = okCount;
    oeBefore = oeCount;
    for (int i = 4; i >= 0; i--) clockBit(txQ[2][i], s);
    clockBit(1'b1, s);
    checkOutput("rstMid ignored oe", 64'(oeCount - oeBefore), 64'(0));
    checkOutput("rstMid ignored ok", 64'(okCount - okBefore), 64'(0));
    checkOutput("rstMid ignored regs", 64'(REGS), 64'(modelFlat()));
    busStop();

    $display("[TB] recovery write");
    txQ = '{8'h84, 8'h00, 8'h5A, 8'hC3};
    applyStimulus("recover");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter ADDR, default 7'h42: 7-bit bus address the block answers to.
REQ-002 SHALL have parameter NUM_REGS, default 4, range 1..16: number of 8-bit registers.
REQ-003 SHALL have port CLK  input  1: the single system clock; all logic SHALL be rising-edge CLK only.
REQ-004 SHALL have port RST  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port SCL  input  1: bus clock from the controller, asynchronous to CLK.
REQ-006 SHALL have port SDA_IN  input  1: sampled bus data line, asynchronous to CLK.
REQ-007 SHALL have port SDA_OE  output  1: 1 = pull SDA low, 0 = release; the enclosing top builds the open-drain pad.
REQ-008 SHALL have port REGS  output  NUM_REGS*8: register file, flattened, reg k at bits [8k+7:8k].
REQ-009 SHALL have port BUSY  output  1: high from an addressed START match until STOP or next START.
REQ-010 SHALL have port OK  output  1: one-CLK pulse for each data byte written into REGS.

Function
REQ-011 SHALL pass SCL and SDA_IN through two-flop synchronisers, then one edge-detect register; CLK SHALL be at least 16x SCL.
REQ-012 SHALL detect START as synchronised SDA falling while synchronised SCL high, STOP as SDA rising while SCL high.
REQ-013 SHALL sample SDA on synchronised SCL rising edges and change SDA_OE only on the first CLK after a synchronised SCL falling edge.
REQ-014 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-015 SHALL go IDLE->ADDR on START; shift 8 bits MSB first (7 address bits + R/W).
REQ-016 SHALL on address match go ADDR_ACK (drive SDA_OE=1 for one SCL period), set BUSY; on mismatch go IGNORE with SDA_OE=0.
REQ-017 SHALL after write-address ACK receive one pointer byte in PTR; pointer < NUM_REGS -> ACK in PTR_ACK, load pointer, go WDATA.
REQ-018 SHALL NACK (SDA_OE=0) a pointer >= NUM_REGS, leave pointer unchanged, and go IGNORE.
REQ-019 SHALL in WDATA, after the 8th bit, write the byte to REGS[pointer] and pulse OK on the same CLK, then ACK in WDATA_ACK.
REQ-020 SHALL auto-increment the pointer after every written or read byte, wrapping NUM_REGS-1 -> 0.
REQ-021 SHALL treat START seen in any state (repeated START) as a new ADDR phase, keeping the pointer.
REQ-022 SHALL on STOP in any state go IDLE, clear BUSY, release SDA_OE within one CLK; a partial byte SHALL be discarded.
REQ-023 SHALL in IGNORE hold SDA_OE=0 and wait for START or STOP.
REQ-024 SHALL give START/STOP priority over a data sample when both are detected on the same CLK.

Reset
REQ-025 SHALL on RST=1 at a CLK edge set state IDLE, SDA_OE=0, BUSY=0, OK=0, pointer=0, REGS all 8'h00, synchroniser flops to 1 (idle bus).
REQ-026 SHALL on reset mid-transfer release SDA at the next CLK edge and ignore the bus until a fresh START.

Configuration
REQ-027 SHALL compile read support only when macro I2C_TARGET_READ_EN is defined.
REQ-028 SHALL with I2C_TARGET_READ_EN: on read-address match ACK, then in RDATA shift REGS[pointer] MSB first on SDA_OE (bit 0 -> SDA_OE=1), release in RDATA_ACK and sample controller ACK; ACK -> next byte, NACK -> IGNORE.
REQ-029 SHALL without I2C_TARGET_READ_EN: NACK a matching read address and go IGNORE; RDATA states SHALL not exist.

Verification
REQ-030 SHALL test write: START, 0x84, 0x01, 0xA5, STOP -> three ACKs, REGS[1]=0xA5, one OK pulse, BUSY low after STOP.
REQ-031 SHALL test burst wrap: NUM_REGS=4, write ptr 0x03 then 0x11,0x22 -> REGS[3]=0x11, REGS[0]=0x22, two OK pulses.
REQ-032 SHALL test reject: address 0x90 -> no ACK, SDA_OE never 1, REGS unchanged; pointer 0x07 with NUM_REGS=4 -> NACK, REGS unchanged.
REQ-033 SHALL test read (macro defined): write ptr 0x01, repeated START, 0x85, read two bytes ACK then NACK -> bytes REGS[1], REGS[2]; macro undefined -> 0x85 NACKed.
REQ-034 SHALL test abort: STOP after 4 data bits, then RST asserted mid-byte of a new write -> no REGS change, SDA_OE=0 next CLK, all outputs at reset values.
